alu: RTL and testbench



---
 rtl/gpu_pkg.sv | 41 ++++
 rtl/alu_div.sv | 28 ++
 rtl/alu.sv | 57 +++++
 tb/tb_alu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU compute core types: core FSM states and ALU opcodes.
// Imported by every core-side block that decodes state or opcode.
package gpu_pkg;

  localparam int DATA_W = 8;

  // Full 3-bit encoding of the core FSM; owned by the core controller.
  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  localparam logic [DATA_W-1:0] DIV_ZERO_Q = 8'hFF;

  // NZP word: {00000, gt, eq, lt}; exactly one low bit set.
  function automatic logic [DATA_W-1:0] nzp(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    r[2] = a > b;
    r[1] = a == b;
    r[0] = a < b;
    return r;
  endfunction

endpackage

// File: rtl/alu_div.sv
// Combinational 8-bit unsigned restoring divider, 8 stages.
// Ports: dividend, divisor in; quotient out (8'hFF on divide by zero).
module alu_div
  import gpu_pkg::*;
(
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient
);

  logic [8:0] rem;
  logic [7:0] quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = 7; i >= 0; i--) begin
      rem = {rem[7:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem    = rem - {1'b0, divisor};
        quo[i] = 1'b1;
      end
    end
  end

  assign quotient = (divisor == '0) ? DIV_ZERO_Q : quo;

endmodule

// File: rtl/alu.sv
// Per-thread 8-bit ALU: add/sub/mul/div or NZP compare, registered.
// Ports: clk, reset (async low), enable, core_state, opcode, output_mux, rs, rt -> alu_output.
module alu
  import gpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] core_state,
  input  logic [1:0] opcode,
  input  logic       output_mux,
  input  logic [7:0] rs,
  input  logic [7:0] rt,
  output logic [7:0] alu_output
);

  logic [7:0] div_q;
  logic [7:0] arith;
  logic [7:0] cmp;
  logic       upd;
  logic [7:0] alu_output_d;
  logic [7:0] alu_output_q;

  alu_div u_div (
    .dividend (rs),
    .divisor  (rt),
    .quotient (div_q)
  );

  always_comb begin
    arith = '0;
    unique case (alu_op_e'(opcode))
      ALU_ADD: arith = rs + rt;
      ALU_SUB: arith = rs - rt;
      ALU_MUL: arith = rs * rt;
      ALU_DIV: arith = div_q;
    endcase
  end

  assign cmp = nzp(rs, rt);
  assign upd = enable &&
    (core_state_e'(core_state) == CS_EXECUTE);

  always_comb begin
    alu_output_d = alu_output_q;
    if (upd)
      alu_output_d = output_mux ? cmp : arith;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_output_q <= '0;
    else        alu_output_q <= alu_output_d;
  end

  assign alu_output = alu_output_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan steps plus random
// stimulus against an arithmetic reference model.
module tb_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] core_state = 3'b000;
  logic [1:0] opcode = 2'b00;
  logic       output_mux = 1'b0;
  logic [7:0] rs = 8'd0;
  logic [7:0] rt = 8'd0;
  logic [7:0] alu_output;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_v = 8'h00;

  alu dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .core_state (core_state),
    .opcode     (opcode),
    .output_mux (output_mux),
    .rs         (rs),
    .rt         (rt),
    .alu_output (alu_output)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(
    input int op, input int m, input int a, input int b
  );
    int r;
    if (m != 0) begin
      if (a > b)       r = 4;
      else if (a == b) r = 2;
      else             r = 1;
    end else begin
      case (op)
        0:       r = (a + b) % 256;
        1:       r = (a - b + 256) % 256;
        2:       r = (a * b) % 256;
        default: r = (b == 0) ? 255 : a / b;
      endcase
    end
    return r[7:0];
  endfunction

  task automatic check(
    input string tag, input logic [7:0] obs, input logic [7:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; applies inputs, crosses one rising edge,
  // checks at the following negedge.
  task automatic step(
    input string tag, input logic en, input logic [2:0] cs,
    input logic [1:0] op, input logic m,
    input logic [7:0] a, input logic [7:0] b
  );
    enable = en; core_state = cs; opcode = op;
    output_mux = m; rs = a; rt = b;
    @(negedge clk);
    if (en && cs == 3'd5)
      exp_v = model(int'(op), int'(m), int'(a), int'(b));
    check(tag, alu_output, exp_v);
  endtask

  localparam logic [2:0] EX = 3'b101;

  initial begin
    enable = 1'b1; core_state = EX; opcode = 2'b00;
    rs = 8'd3; rt = 8'd4;
    #1 reset = 1'b0;
    #1 check("reset_async", alu_output, 8'h00);
    repeat (3) @(negedge clk);
    check("reset_hold", alu_output, 8'h00);
    reset = 1'b1;
    exp_v = 8'h00;

    step("sub_24_8",   1, EX, 2'b01, 0, 8'd24, 8'd8);
    step("cmp_24_8",   1, EX, 2'b01, 1, 8'd24, 8'd8);
    step("sub_45_9",   1, EX, 2'b01, 0, 8'd45, 8'd9);
    step("cmp_eq",     1, EX, 2'b01, 1, 8'd7,  8'd7);
    step("cmp_lt",     1, EX, 2'b01, 1, 8'd3,  8'd9);
    step("mul_45_9",   1, EX, 2'b10, 0, 8'd45, 8'd9);
    step("div_45_9",   1, EX, 2'b11, 0, 8'd45, 8'd9);
    step("div_by_0",   1, EX, 2'b11, 0, 8'd45, 8'd0);
    step("div_7_9",    1, EX, 2'b11, 0, 8'd7,  8'd9);
    step("add_wrap",   1, EX, 2'b00, 0, 8'd200, 8'd100);
    step("sub_wrap",   1, EX, 2'b01, 0, 8'd8,  8'd24);
    step("div_255_1",  1, EX, 2'b11, 0, 8'd255, 8'd1);
    step("div_0_0",    1, EX, 2'b11, 0, 8'd0,  8'd0);

    step("pre_gate",   1, EX, 2'b01, 0, 8'd24, 8'd8);
    check("pre_gate_16", alu_output, 8'h10);
    step("gate_state", 1, 3'b011, 2'b00, 0, 8'd1, 8'd1);
    step("gate_en",    0, EX, 2'b10, 1, 8'd9, 8'd3);
    check("gate_hold16", alu_output, 8'h10);
    step("ungate",     1, EX, 2'b00, 0, 8'd1, 8'd1);

    // Reset pulse between edges: clears without any clock edge.
    step("pre_rst",    1, EX, 2'b10, 0, 8'd6, 8'd7);
    #1 reset = 1'b0;
    #1 check("mid_reset", alu_output, 8'h00);
    #1 reset = 1'b1;
    #1 check("post_rel", alu_output, 8'h00);
    exp_v = 8'h00;
    @(negedge clk);
    exp_v = model(2, 0, 6, 7);
    check("recompute", alu_output, exp_v);

    for (int i = 0; i < 300; i++) begin
      logic        en;
      logic [2:0]  cs;
      logic [7:0]  b;
      en = ($urandom_range(0, 7) != 0);
      cs = ($urandom_range(0, 3) != 0) ? EX
           : 3'($urandom_range(0, 7));
      b  = ($urandom_range(0, 9) == 0) ? 8'd0
           : 8'($urandom);
      step("rand", en, cs, 2'($urandom),
           1'($urandom), 8'($urandom), b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
